// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter over 256-tick windows; reports changed duty values through a UART handshake.
// Build option: define PWM_DUTY_METER_HEX_EN to send each report as two ASCII hex digits plus CR.
`timescale 1ns/1ps
module pwm_duty_meter #(
   parameter int unsigned DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_in,
   input  logic       enable,
   input  logic       tx_busy,
   output logic       transmit,
   output logic [7:0] tx_byte,
   output logic [7:0] duty,
   output logic       duty_valid
);
   localparam int unsigned DIV_W = 16;
   localparam int unsigned CHR_W = 2;
`ifdef PWM_DUTY_METER_HEX_EN
   localparam int unsigned N_CHR = 3;
`else
   localparam int unsigned N_CHR = 1;
`endif
   localparam logic [CHR_W-1:0] LAST_CHR = CHR_W'(N_CHR - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_END} state_t;

   state_t             state, state_n_c;
   logic               pwm_meta, pwm_s;
   logic [DIV_W-1:0]   div_cnt;
   logic [7:0]         win_cnt;
   logic [8:0]         hi_cnt;
   logic               tick_c;
   logic [8:0]         hi_sum_c;
   logic               candidate_c;
   logic               pending, sent_once;
   logic [7:0]         pend_val, cur_val, last_sent;
   logic [CHR_W-1:0]   chr_idx, chr_n_c;
   logic               fire_c, load_cur_c, done_c;
   logic [7:0]         src_c, char_c;

`ifdef PWM_DUTY_METER_HEX_EN
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
   endfunction
`endif

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_meta <= 1'b0;
         pwm_s    <= 1'b0;
      end else begin
         pwm_meta <= pwm_in;
         pwm_s    <= pwm_meta;
      end
   end

   assign tick_c   = (div_cnt == DIV_W'(DIV - 1));
   assign hi_sum_c = hi_cnt + 9'(pwm_s);

   // Sample divider and window counters; the closing tick includes its own sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         win_cnt    <= '0;
         hi_cnt     <= '0;
         duty       <= '0;
         duty_valid <= 1'b0;
      end else if (!enable) begin
         div_cnt    <= '0;
         win_cnt    <= '0;
         hi_cnt     <= '0;
         duty_valid <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         div_cnt    <= tick_c ? '0 : div_cnt + DIV_W'(1);
         if (tick_c) begin
            win_cnt <= win_cnt + 8'd1;
            if (win_cnt == 8'hFF) begin
               duty       <= hi_sum_c[8] ? 8'hFF : hi_sum_c[7:0];
               hi_cnt     <= '0;
               duty_valid <= 1'b1;
            end else if (pwm_s) begin
               hi_cnt <= hi_cnt + 9'd1;
            end
         end
      end
   end

   assign candidate_c = duty_valid && (!sent_once || (duty != last_sent));

   // Latest-wins pending slot; a fresh candidate beats the IDLE->LOAD clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         pend_val <= '0;
      end else if (candidate_c) begin
         pending  <= 1'b1;
         pend_val <= duty;
      end else if (load_cur_c) begin
         pending  <= 1'b0;
      end
   end

   // Next-state logic; fire_c is the registered transmit strobe request
   always_comb begin
      state_n_c  = state;
      chr_n_c    = chr_idx;
      fire_c     = 1'b0;
      load_cur_c = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               state_n_c  = LOAD;
               load_cur_c = 1'b1;
               chr_n_c    = '0;
               fire_c     = !tx_busy;
            end
         end
         LOAD: begin
            if (transmit)      state_n_c = WAIT_START;
            else if (!tx_busy) fire_c    = 1'b1;
         end
         WAIT_START: begin
            if (tx_busy) state_n_c = WAIT_END;
         end
         WAIT_END: begin
            if (!tx_busy) begin
               if (chr_idx == LAST_CHR) begin
                  state_n_c = IDLE;
                  done_c    = 1'b1;
               end else begin
                  state_n_c = LOAD;
                  chr_n_c   = chr_idx + CHR_W'(1);
                  fire_c    = 1'b1;
               end
            end
         end
         default: state_n_c = IDLE;
      endcase
   end

   // Character for the strobe being requested; cur_val is not yet loaded on IDLE->LOAD
   always_comb begin
      src_c = load_cur_c ? pend_val : cur_val;
`ifdef PWM_DUTY_METER_HEX_EN
      case (chr_n_c)
         2'd0:    char_c = hex_ascii(src_c[7:4]);
         2'd1:    char_c = hex_ascii(src_c[3:0]);
         default: char_c = 8'h0D;
      endcase
`else
      char_c = src_c;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         chr_idx   <= '0;
         cur_val   <= '0;
         last_sent <= '0;
         sent_once <= 1'b0;
         transmit  <= 1'b0;
         tx_byte   <= '0;
      end else begin
         state    <= state_n_c;
         chr_idx  <= chr_n_c;
         transmit <= fire_c;
         if (fire_c)     tx_byte <= char_c;
         if (load_cur_c) cur_val <= pend_val;
         if (done_c) begin
            last_sent <= cur_val;
            sent_once <= 1'b1;
         end
      end
   end

endmodule
